i2s_stream_controller: RTL and testbench

// Parametrised successor memory-to-I2S sample streamer; sits between the wishbone/DMA memory reader and the I2S serialiser.

---
 rtl/i2s_pkg.sv | 28 ++
 rtl/i2s_sample_fifo.sv | 52 +++++
 rtl/i2s_stream_controller.sv | 161 ++++++++++++++++
 tb/tb_i2s_stream_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S stream controller slice.
// Holds operating modes, refill FSM states and the mode decode helper.
package i2s_pkg;

    typedef enum logic [1:0] {
        MODE_MEM       = 2'd0,
        MODE_TONE_PRE  = 2'd1,
        MODE_TONE_POST = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } refill_state_e;

    // Code 3 is an alias of memory playback.
    function automatic mode_e decode_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'd1:    r = MODE_TONE_PRE;
            2'd2:    r = MODE_TONE_POST;
            default: r = MODE_MEM;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous show-ahead FIFO of 32-bit words, depth 2**AW.
// Ports: clk, rst, flush_i, push_i/wdata_i, pop_i/rdata_o, level_o, full_o, empty_o.
module i2s_sample_fifo #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [31:0]   wdata_i,
    input  logic          pop_i,
    output logic [31:0]   rdata_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);
    import i2s_pkg::*;

    logic [31:0] mem_q [2**AW];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        do_pop;
    logic        do_push;

    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign level_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // A pop in the same cycle frees the slot a full FIFO writes into.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/i2s_stream_controller.sv
// Memory-to-I2S sample streamer: burst refill FSM, FIFO, tone generator,
// req/ack sample serve with channel rotation, underrun and overflow status.
module i2s_stream_controller #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int NUM_CHANNELS = 2,
    parameter int FIFO_AW      = 6,
    parameter int BURST        = 16,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [15:0]             tone_step,
    output logic                    request_data,
    output logic [23:0]             request_size,
    input  logic                    request_finished,
    input  logic                    memory_data_strobe,
    input  logic [31:0]             memory_data,
    input  logic                    audio_data_request,
    output logic                    audio_data_ack,
    output logic [SAMPLE_WIDTH-1:0] audio_data,
    output logic [CW-1:0]           audio_channel,
    output logic [FIFO_AW:0]        fifo_level,
    output logic [15:0]             underrun_count,
    output logic                    overflow
);
    import i2s_pkg::*;

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2**FIFO_AW);

    mode_e                   md;
    refill_state_e           state_q, state_d;
    logic                    ack_q, ack_d;
    logic [SAMPLE_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]           chan_q, chan_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic [15:0]             phase_q, phase_d;
    logic [15:0]             urun_q, urun_d;
    logic                    ovf_q, ovf_d;

    logic                    serve;
    logic                    wrap;
    logic [SAMPLE_WIDTH-1:0] tone;
    logic                    f_flush, f_push, f_pop, f_full, f_empty;
    logic [31:0]             f_wdata, f_rdata;
    logic [FIFO_AW:0]        free;
    logic                    unused_rdata;

    assign md    = decode_mode(mode);
    assign tone  = SAMPLE_WIDTH'({phase_q, 16'h0} >> (32 - SAMPLE_WIDTH));
    assign serve = enable && audio_data_request && !ack_q;
    assign wrap  = (ch_q == CW'(NUM_CHANNELS - 1));
    assign free  = DEPTH - fifo_level;
    assign unused_rdata = ^f_rdata[31:SAMPLE_WIDTH];

    assign request_data   = (state_q == ST_REQ);
    assign request_size   = 24'(BURST);
    assign audio_data_ack = ack_q;
    assign audio_data     = data_q;
    assign audio_channel  = chan_q;
    assign underrun_count = urun_q;
    assign overflow       = ovf_q;

    // FIFO port control; memory strobes take priority over tone fill.
    always_comb begin
        f_flush = !enable || (md == MODE_TONE_POST);
        f_pop   = serve && (md != MODE_TONE_POST) && !f_empty;
        f_push  = 1'b0;
        f_wdata = memory_data;
        if (memory_data_strobe) begin
            f_push = 1'b1;
        end else if (md == MODE_TONE_PRE) begin
            f_push  = 1'b1;
            f_wdata = 32'(tone);
        end
    end

    i2s_sample_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (f_flush),
        .push_i  (f_push),
        .wdata_i (f_wdata),
        .pop_i   (f_pop),
        .rdata_o (f_rdata),
        .level_o (fifo_level),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (md == MODE_MEM && free >= (FIFO_AW+1)'(BURST))
                             state_d = ST_REQ;
                ST_REQ:  state_d = ST_WAIT;
                ST_WAIT: if (request_finished) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ack_d   = ack_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ch_d    = ch_q;
        phase_d = phase_q;
        urun_d  = urun_q;
        ovf_d   = ovf_q;
        if (enable && memory_data_strobe && md != MODE_TONE_POST &&
            f_full && !f_pop)
            ovf_d = 1'b1;
        if (!enable) begin
            ack_d = 1'b0;
            ch_d  = '0;
        end else if (serve) begin
            ack_d  = 1'b1;
            chan_d = ch_q;
            ch_d   = wrap ? '0 : ch_q + 1'b1;
            if (wrap) phase_d = phase_q + tone_step;
            if (md == MODE_TONE_POST) begin
                data_d = tone;
            end else if (!f_empty) begin
                data_d = f_rdata[SAMPLE_WIDTH-1:0];
            end else begin
                data_d = '0;
                if (urun_q != 16'hFFFF) urun_d = urun_q + 1'b1;
            end
        end else if (!audio_data_request) begin
            ack_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ch_q    <= '0;
            phase_q <= '0;
            urun_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ch_q    <= ch_d;
            phase_q <= phase_d;
            urun_q  <= urun_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_i2s_stream_controller.sv
// Directed bench for i2s_stream_controller (FIFO_AW=3, BURST=4, 2 channels).
// Expected values are hand-derived constants checked by immediate assertions.
module tb_i2s_stream_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] tone_step;
    logic        request_data;
    logic [23:0] request_size;
    logic        request_finished;
    logic        memory_data_strobe;
    logic [31:0] memory_data;
    logic        audio_data_request;
    logic        audio_data_ack;
    logic [23:0] audio_data;
    logic [0:0]  audio_channel;
    logic [3:0]  fifo_level;
    logic [15:0] underrun_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    i2s_stream_controller #(
        .SAMPLE_WIDTH(24),
        .NUM_CHANNELS(2),
        .FIFO_AW(3),
        .BURST(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .mode               (mode),
        .tone_step          (tone_step),
        .request_data       (request_data),
        .request_size       (request_size),
        .request_finished   (request_finished),
        .memory_data_strobe (memory_data_strobe),
        .memory_data        (memory_data),
        .audio_data_request (audio_data_request),
        .audio_data_ack     (audio_data_ack),
        .audio_data         (audio_data),
        .audio_channel      (audio_channel),
        .fifo_level         (fifo_level),
        .underrun_count     (underrun_count),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic serve(input string tag, input logic [31:0] exp_d,
                         input logic [31:0] exp_c, input bit chk_c);
        bit got;
        audio_data_request = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            tick();
            got = audio_data_ack;
        end
        chk({tag, "_ack"}, 32'(got), 32'd1);
        chk({tag, "_data"}, 32'(audio_data), exp_d);
        if (chk_c) chk({tag, "_ch"}, 32'(audio_channel), exp_c);
        audio_data_request = 1'b0;
        for (int n = 0; n < 8 && got; n++) begin
            tick();
            got = audio_data_ack;
        end
        chk({tag, "_ackfall"}, 32'(got), 32'd0);
    endtask

    task automatic strobe(input logic [31:0] d);
        memory_data_strobe = 1'b1;
        memory_data = d;
        tick();
        memory_data_strobe = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        mode = 2'd0;
        tone_step = 16'h0;
        request_finished = 1'b0;
        memory_data_strobe = 1'b0;
        memory_data = '0;
        audio_data_request = 1'b0;
        tick();
        tick();
        chk("rst_ack", 32'(audio_data_ack), 0);
        chk("rst_data", 32'(audio_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_req", 32'(request_data), 0);
        chk("rst_urun", 32'(underrun_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("req_size", 32'(request_size), 4);

        rst = 1'b0;
        enable = 1'b1;
        tick();
        chk("burst_req", 32'(request_data), 1);
        tick();
        chk("burst_req_pulse", 32'(request_data), 0);
        for (int i = 0; i < 4; i++) strobe(32'h11 + 32'(i));
        chk("burst_level", 32'(fifo_level), 4);
        request_finished = 1'b1;
        tick();
        request_finished = 1'b0;
        serve("mem0", 32'h11, 0, 1'b1);
        serve("mem1", 32'h12, 1, 1'b1);
        serve("mem2", 32'h13, 0, 1'b1);
        serve("mem3", 32'h14, 1, 1'b1);
        chk("mem_level", 32'(fifo_level), 0);

        serve("urun0", 0, 0, 1'b1);
        serve("urun1", 0, 1, 1'b1);
        serve("urun2", 0, 0, 1'b1);
        chk("urun_cnt", 32'(underrun_count), 3);

        for (int i = 0; i < 9; i++) strobe(32'h21 + 32'(i));
        chk("full_level", 32'(fifo_level), 8);
        chk("full_ovf", 32'(overflow), 1);
        audio_data_request = 1'b1;
        memory_data_strobe = 1'b1;
        memory_data = 32'h2A;
        tick();
        memory_data_strobe = 1'b0;
        chk("pp_ack", 32'(audio_data_ack), 1);
        chk("pp_data", 32'(audio_data), 32'h21);
        chk("pp_level", 32'(fifo_level), 8);
        audio_data_request = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) serve("drain", 32'h22 + 32'(i), 0, 1'b0);
        serve("drain_last", 32'h2A, 0, 1'b0);
        chk("drain_level", 32'(fifo_level), 0);
        chk("drain_urun", 32'(underrun_count), 3);

        strobe(32'h31);
        strobe(32'h32);
        audio_data_request = 1'b1;
        tick();
        chk("pre_rst_ack", 32'(audio_data_ack), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ack", 32'(audio_data_ack), 0);
        chk("async_data", 32'(audio_data), 0);
        chk("async_level", 32'(fifo_level), 0);
        chk("async_urun", 32'(underrun_count), 0);
        chk("async_ovf", 32'(overflow), 0);
        chk("async_req", 32'(request_data), 0);
        audio_data_request = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("fresh_req", 32'(request_data), 1);
        tick();

        serve("wait_urun", 0, 0, 1'b1);
        strobe(32'h41);
        strobe(32'h42);
        chk("wait_level", 32'(fifo_level), 2);
        enable = 1'b0;
        tick();
        request_finished = 1'b1;
        tick();
        request_finished = 1'b0;
        tick();
        chk("dis_level", 32'(fifo_level), 0);
        chk("dis_urun", 32'(underrun_count), 1);
        chk("dis_req", 32'(request_data), 0);

        enable = 1'b1;
        mode = 2'd2;
        tone_step = 16'h0100;
        tick();
        chk("post_noreq", 32'(request_data), 0);
        serve("tone0", 32'h000000, 0, 1'b1);
        serve("tone1", 32'h000000, 1, 1'b1);
        serve("tone2", 32'h010000, 0, 1'b1);
        serve("tone3", 32'h010000, 1, 1'b1);
        chk("post_level", 32'(fifo_level), 0);
        chk("post_urun", 32'(underrun_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
